fetch_sequencer: RTL and testbench

//  Program-counter and fetch control for the washing register machine. Drives pc into the

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_wait_timer.sv | 35 +++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA definitions for the washing register machine: opcode values,
// instruction field positions and the fetch FSM state encoding.
package fetch_sequencer_pkg;

  // Instruction fields: [15:12] opcode, [11:8] register, [7:0] immediate/target.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_WAIT = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// WAIT down-counter. Loaded with the WAIT immediate on entry, decremented by
// each qualified tick; done flags the tick that retires the final count.
module wait_timer
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              tick,
  output logic              done
);

  logic [WAIT_W-1:0] cnt;

  // Load has priority so a tick arriving with the load is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (load) begin
        cnt <= load_val;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - WAIT_W'(1);
      end
    end
  end

  assign done = tick && (cnt == WAIT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch control. Executes NOP/JMP/JZ/WAIT/HALT locally and
// issues every other opcode to the execute stage over valid/ready.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int WAIT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tick,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] exec_instr,
  output logic               exec_valid,
  input  logic               exec_ready,
  output logic               waiting,
  output logic               halted
);

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [3:0]        opcode;
  logic [IMM_W-1:0]  imm;
  logic              issue_load;
  logic              issue_clear;
  logic              wait_load;
  logic              wait_done;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];
  assign pc_inc = pc + PC_W'(1);
  assign target = PC_W'(imm);

  wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (wait_load),
    .load_val (WAIT_W'(imm)),
    .tick     (tick && (state == ST_WAIT)),
    .done     (wait_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next-state, next-pc and register load strobes; nothing moves while en=0.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next  = state;
    pc_next     = pc;
    issue_load  = 1'b0;
    issue_clear = 1'b0;
    wait_load   = 1'b0;
    if (en) begin
      unique case (state)
        ST_FETCH: begin
          unique case (opcode)
            OP_NOP:  pc_next = pc_inc;
            OP_JMP:  pc_next = target;
            OP_JZ:   pc_next = zero_flag ? target : pc_inc;
            OP_WAIT: begin
              if (imm == '0) begin
                pc_next = pc_inc;
              end else begin
                wait_load  = 1'b1;
                state_next = ST_WAIT;
              end
            end
            OP_HALT: state_next = ST_HALT;
            default: begin
              issue_load = 1'b1;
              pc_next    = pc_inc;
              state_next = ST_ISSUE;
            end
          endcase
        end
        ST_ISSUE: begin
          if (exec_ready) begin
            issue_clear = 1'b1;
            state_next  = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end
        end
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    waiting = (state == ST_WAIT);
    halted  = (state == ST_HALT);
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  // Issue register: captured on issue, held until the execute handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid <= 1'b0;
      exec_instr <= '0;
    end else if (issue_load) begin
      exec_valid <= 1'b1;
      exec_instr <= instr;
    end else if (issue_clear) begin
      exec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run compared against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic        zero_flag = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [15:0] exec_instr;
  logic        exec_valid;
  logic        exec_ready = 1'b0;
  logic        waiting;
  logic        halted;

  logic [15:0] prog [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign instr = prog[pc];

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tick       (tick),
    .zero_flag  (zero_flag),
    .pc         (pc),
    .instr      (instr),
    .exec_instr (exec_instr),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .waiting    (waiting),
    .halted     (halted)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Leaves the bench 1 time unit after a rising edge with pc at 0.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    load_nops();
    prog[0] = 16'h3123;
    exec_ready = 1'b0;
    do_reset();
    step(1);
    n_cmp++;
    if (exec_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_valid: got %b want 1", exec_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_cmp++;
    if (exec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", exec_valid); end
    n_cmp++;
    if (exec_instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h want 0000", exec_instr); end
    n_cmp++;
    if (halted !== 1'b0 || waiting !== 1'b0) begin
      n_err++; $display("FAIL reset_status: got halted=%b waiting=%b want 0 0", halted, waiting);
    end
    rst = 1'b0;
  endtask

  task automatic test_jmp();
    logic [7:0] seq [11];
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h02, 8'h03, 8'h04};
    load_nops();
    prog[8] = 16'hA002;
    do_reset();
    n_cmp++;
    if (pc !== 8'h00) begin n_err++; $display("FAIL jmp_start: got %h want 00", pc); end
    for (int i = 0; i < 11; i++) begin
      step(1);
      n_cmp++;
      if (pc !== seq[i]) begin n_err++; $display("FAIL jmp_seq[%0d]: got %h want %h", i, pc, seq[i]); end
    end
  endtask

  task automatic test_jz();
    for (int z = 1; z >= 0; z--) begin
      load_nops();
      prog[5] = 16'hB020;
      zero_flag = z[0];
      do_reset();
      step(5);
      n_cmp++;
      if (pc !== 8'h05) begin n_err++; $display("FAIL jz_at5 z=%0d: got %h want 05", z, pc); end
      step(1);
      n_cmp++;
      if (pc !== (z == 1 ? 8'h20 : 8'h06)) begin
        n_err++; $display("FAIL jz_target z=%0d: got %h want %h", z, pc, (z == 1 ? 8'h20 : 8'h06));
      end
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_wait();
    int ticks = 0;
    int bad_pc = 0;
    bit left = 0;
    load_nops();
    prog[0] = 16'hA010;
    prog[16] = 16'hC003;
    do_reset();
    step(1);
    tick = 1'b1;              // coincides with entry; must not count
    step(1);
    tick = 1'b0;
    n_cmp++;
    if (waiting !== 1'b1 || pc !== 8'h10) begin
      n_err++; $display("FAIL wait_entry: got waiting=%b pc=%h want 1 10", waiting, pc);
    end
    for (int k = 0; k < 40; k++) begin
      if (waiting !== 1'b1) begin left = 1; break; end
      if (pc !== 8'h10) bad_pc++;
      tick = (k % 4 == 3);
      if (tick) ticks++;
      step(1);
      tick = 1'b0;
    end
    n_cmp++;
    if (!left || ticks != 3) begin
      n_err++; $display("FAIL wait_ticks: got %0d ticks (left=%0d) want 3", ticks, left);
    end
    n_cmp++;
    if (pc !== 8'h11 || bad_pc != 0) begin
      n_err++; $display("FAIL wait_pc: got %h (held errs %0d) want 11", pc, bad_pc);
    end
    prog[16] = 16'hC000;
    do_reset();
    step(2);
    n_cmp++;
    if (pc !== 8'h11 || waiting !== 1'b0) begin
      n_err++; $display("FAIL wait0: got pc=%h waiting=%b want 11 0", pc, waiting);
    end
    load_nops();
    prog[0] = 16'hC0C8;
    do_reset();
    step(4);
    n_cmp++;
    if (waiting !== 1'b1) begin n_err++; $display("FAIL wait_long: got %b want 1", waiting); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (waiting !== 1'b0 || pc !== 8'h00) begin
      n_err++; $display("FAIL wait_rst: got waiting=%b pc=%h want 0 00", waiting, pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_issue();
    int unstable = 0;
    load_nops();
    prog[4] = 16'h3A5C;
    exec_ready = 1'b0;
    do_reset();
    step(5);
    for (int c = 0; c < 5; c++) begin
      if (exec_valid !== 1'b1 || exec_instr !== 16'h3A5C || pc !== 8'h05) unstable++;
      if (c < 4) step(1);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_err++; $display("FAIL issue_hold: got %0d bad cycles (valid=%b instr=%h pc=%h) want 0",
                        unstable, exec_valid, exec_instr, pc);
    end
    exec_ready = 1'b1;
    step(1);
    exec_ready = 1'b0;
    n_cmp++;
    if (exec_valid !== 1'b0 || pc !== 8'h05) begin
      n_err++; $display("FAIL issue_accept: got valid=%b pc=%h want 0 05", exec_valid, pc);
    end
    step(1);
    n_cmp++;
    if (pc !== 8'h06) begin n_err++; $display("FAIL issue_resume: got %h want 06", pc); end
  endtask

  task automatic test_halt();
    int bad = 0;
    load_nops();
    prog[0] = 16'hA0FF;
    prog[255] = 16'hF000;
    do_reset();
    step(2);
    for (int c = 0; c < 20; c++) begin
      if (halted !== 1'b1 || pc !== 8'hFF) bad++;
      step(1);
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL halt_hold: got %0d bad cycles pc=%h want 0", bad, pc); end
    prog[255] = 16'h0000;
    do_reset();
    step(2);
    n_cmp++;
    if (pc !== 8'h00 || halted !== 1'b0) begin
      n_err++; $display("FAIL pc_wrap: got pc=%h halted=%b want 00 0", pc, halted);
    end
  endtask

  // Instruction-level model: one record of "what the machine is doing".
  task automatic test_random();
    int m_pc, m_left, halt_age;
    bit m_pend, m_halt;
    logic [15:0] m_exec;
    int op, imm;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3:      prog[i] = 16'h0000;
        4, 5:            prog[i] = {4'hA, 4'h0, 8'($urandom)};
        6, 7:            prog[i] = {4'hB, 4'h0, 8'($urandom)};
        8, 9, 10:        prog[i] = {4'hC, 4'h0, 8'($urandom_range(0, 4))};
        11:              prog[i] = 16'hF000;
        default: begin
          op = $urandom_range(0, 10);
          op = (op < 9) ? op + 1 : op + 4;
          prog[i] = {4'(op), 12'($urandom)};
        end
      endcase
    end
    do_reset();
    m_pc = 0; m_left = 0; m_pend = 0; m_halt = 0; m_exec = 16'h0000; halt_age = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ((m_halt && ++halt_age > 3) || $urandom_range(0, 99) == 0) begin
        rst = 1'b1; #2; rst = 1'b0;
        m_pc = 0; m_left = 0; m_pend = 0; m_halt = 0; m_exec = 16'h0000; halt_age = 0;
      end
      en = ($urandom_range(0, 99) < 85);
      tick = ($urandom_range(0, 99) < 30);
      exec_ready = $urandom_range(0, 1);
      zero_flag = $urandom_range(0, 1);
      if (en) begin
        if (m_halt) begin
        end else if (m_pend) begin
          if (exec_ready) m_pend = 0;
        end else if (m_left > 0) begin
          if (tick) begin
            m_left--;
            if (m_left == 0) m_pc = (m_pc + 1) % 256;
          end
        end else begin
          op = prog[m_pc] >> 12;
          imm = prog[m_pc] % 256;
          if (op == 0) m_pc = (m_pc + 1) % 256;
          else if (op == 10) m_pc = imm;
          else if (op == 11) m_pc = zero_flag ? imm : (m_pc + 1) % 256;
          else if (op == 12) begin
            if (imm == 0) m_pc = (m_pc + 1) % 256;
            else m_left = imm;
          end else if (op == 15) m_halt = 1;
          else begin
            m_pend = 1; m_exec = prog[m_pc]; m_pc = (m_pc + 1) % 256;
          end
        end
      end
      step(1);
      n_cmp++;
      if (pc !== 8'(m_pc) || exec_valid !== m_pend || waiting !== (m_left > 0) || halted !== m_halt
          || (m_pend && exec_instr !== m_exec)) begin
        n_err++;
        $display("FAIL random cyc %0d: got pc=%h v=%b ei=%h w=%b h=%b want pc=%h v=%b ei=%h w=%b h=%b",
                 cyc, pc, exec_valid, exec_instr, waiting, halted,
                 8'(m_pc), m_pend, m_exec, (m_left > 0), m_halt);
      end
    end
    en = 1'b1;
    tick = 1'b0;
    exec_ready = 1'b0;
    zero_flag = 1'b0;
  endtask

  initial begin
    load_nops();
    step(2);
    test_reset();
    test_jmp();
    test_jz();
    test_wait();
    test_issue();
    test_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
